// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D cache memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam int unsigned BEATS    = 4;
  localparam int unsigned BEAT_W   = 2;
  localparam int unsigned LINE_OFF = 4;

  // Word address of one beat inside a cache line.
  function automatic logic [31:0] beat_addr(input logic [31-LINE_OFF:0] line_base,
                                            input logic [BEAT_W-1:0]     beat);
    return {line_base, beat, 2'b00};
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side bus of the arbiter.
// slave: arbiter view; master: view of the caches and memory around it.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                i_req;
  logic [31:0]         i_addr;
  logic                i_valid;
  logic [31:0]         i_rdata;
  logic                i_done;

  logic                d_req;
  logic                d_we;
  logic [31:0]         d_addr;
  logic [31:0]         d_wdata;
  logic [BEAT_W-1:0]   d_beat;
  logic                d_valid;
  logic [31:0]         d_rdata;
  logic                d_done;

  logic                m_req;
  logic                m_we;
  logic [31:0]         m_addr;
  logic [31:0]         m_wdata;
  logic                m_ack;
  logic [31:0]         m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    output i_valid, i_rdata, i_done, d_beat, d_valid, d_rdata, d_done,
           m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    input  i_valid, i_rdata, i_done, d_beat, d_valid, d_rdata, d_done,
           m_req, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the I-cache and D-cache 4-beat line bursts
// to a single main-memory port.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clock,
  input  logic          resetn,
  mem_arbiter_if.slave  bus
);

  state_t                state_q,      state_d;
  logic [BEAT_W-1:0]     beat_q,       beat_d;
  grant_t                last_grant_q, last_grant_d;
  logic [31-LINE_OFF:0]  line_base_q,  line_base_d;
  logic                  we_q,         we_d;
  logic                  m_req_q,      m_req_d;
  logic                  m_we_q,       m_we_d;
  logic                  i_done_q,     i_done_d;
  logic                  d_done_q,     d_done_d;

  logic                  unused_addr_lsbs;

  // Arbitration, beat counting and next-cycle values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    line_base_d  = line_base_q;
    we_d         = we_q;
    m_req_d      = 1'b0;
    m_we_d       = 1'b0;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // D wins a conflict unless it was the last one granted.
        if (bus.d_req && (!bus.i_req || last_grant_q == GRANT_I)) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          line_base_d  = bus.d_addr[31:LINE_OFF];
          we_d         = bus.d_we;
          beat_d       = '0;
          m_req_d      = 1'b1;
          m_we_d       = bus.d_we;
        end else if (bus.i_req) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          line_base_d  = bus.i_addr[31:LINE_OFF];
          beat_d       = '0;
          m_req_d      = 1'b1;
        end
      end

      SERVE_I, SERVE_D: begin
        m_req_d = 1'b1;
        m_we_d  = m_we_q;
        if (bus.m_ack) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d  = DONE;
            m_req_d  = 1'b0;
            m_we_d   = 1'b0;
            i_done_d = (state_q == SERVE_I);
            d_done_d = (state_q == SERVE_D);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered-output flops with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      last_grant_q <= GRANT_I;
      line_base_q  <= '0;
      we_q         <= 1'b0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
      line_base_q  <= line_base_d;
      we_q         <= we_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.i_done  = i_done_q;
  assign bus.d_done  = d_done_q;
  assign bus.m_addr  = beat_addr(line_base_q, beat_q);
  assign bus.m_wdata = (state_q == SERVE_D && we_q) ? bus.d_wdata : '0;
  assign bus.d_beat  = (state_q == SERVE_D) ? beat_q : '0;
  assign bus.i_valid = (state_q == SERVE_I) && bus.m_ack;
  assign bus.d_valid = (state_q == SERVE_D) && bus.m_ack;
  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;

  assign unused_addr_lsbs = ^{bus.i_addr[LINE_OFF-1:0], bus.d_addr[LINE_OFF-1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle table for a single refill plus
// scoreboarded burst sequences (conflicts, writeback, stalls, reset).
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic resetn;
  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign bus.m_rdata = mem_word(bus.m_addr);

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        to_d;
  } beat_t;

  beat_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_mode = 0;     // 0: always, 1: every third cycle, 2: never
  int i_done_cnt = 0;
  int d_done_cnt = 0;
  int i_done_cyc = 0;
  int d_done_cyc = 0;
  int beats_since = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_burst(input logic [31:0] base, input logic we, input logic to_d);
    beat_t e;
    for (int unsigned k = 0; k < 4; k++) begin
      e.addr  = {base[31:4], k[1:0], 2'b00};
      e.we    = we;
      e.wdata = we ? 32'hA0 + k : 32'h0;
      e.to_d  = to_d;
      exp_q.push_back(e);
    end
  endtask

  // One clock: requesters drop their request after seeing done,
  // memory ack follows ack_mode, D-cache supplies 0xA0 + d_beat.
  task automatic tick();
    logic saw_i, saw_d;
    saw_i = bus.i_done;
    saw_d = bus.d_done;
    @(posedge clock);
    #1;
    cyc++;
    if (saw_i) bus.i_req = 1'b0;
    if (saw_d) bus.d_req = 1'b0;
    case (ack_mode)
      0:       bus.m_ack = 1'b1;
      1:       bus.m_ack = (cyc % 3 == 0);
      default: bus.m_ack = 1'b0;
    endcase
    bus.d_wdata = 32'hA0 + {30'd0, bus.d_beat};
  endtask

  task automatic run_until(input int want_i, input int want_d, input int bound, input string name);
    int n = 0;
    while (!(i_done_cnt >= want_i && d_done_cnt >= want_d) && n < bound) begin
      tick();
      n++;
    end
    chk(name, 64'(i_done_cnt >= want_i && d_done_cnt >= want_d), 64'd1);
  endtask

  // Scoreboard: every accepted memory beat is compared against the queue.
  always @(negedge clock) begin
    beat_t e;
    if (resetn) begin
      if (bus.m_req) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {32'd0, bus.m_addr}, 64'd0);
        end else begin
          e = exp_q[0];
          if (bus.m_ack) begin
            void'(exp_q.pop_front());
            beats_since++;
            chk("beat", {bus.m_addr, bus.m_we, bus.i_valid, bus.d_valid,
                         bus.d_beat, 27'd0},
                        {e.addr, e.we, !e.to_d, e.to_d,
                         (e.to_d ? e.addr[3:2] : 2'b00), 27'd0});
            if (e.we)
              chk("wdata", {32'd0, bus.m_wdata}, {32'd0, e.wdata});
            else if (e.to_d)
              chk("d_rdata", {32'd0, bus.d_rdata}, {32'd0, mem_word(e.addr)});
            else
              chk("i_rdata", {32'd0, bus.i_rdata}, {32'd0, mem_word(e.addr)});
          end else begin
            chk("hold", {bus.m_addr, bus.i_valid, bus.d_valid, 30'd0},
                        {e.addr, 2'b00, 30'd0});
          end
        end
      end else if (bus.m_ack) begin
        chk("spurious_ack_valid", {62'd0, bus.i_valid, bus.d_valid}, 64'd0);
      end
      if (bus.i_done || bus.d_done) begin
        chk("beats_per_burst", 64'(beats_since), 64'd4);
        beats_since = 0;
        if (bus.i_done) begin i_done_cnt++; i_done_cyc = cyc; end
        if (bus.d_done) begin d_done_cnt++; d_done_cyc = cyc; end
      end
    end else begin
      beats_since = 0;
    end
  end

  typedef struct {
    logic        i_req;
    logic        m_ack;
    logic [4:0]  exp_flags;   // m_req, i_valid, d_valid, i_done, d_done
    logic        chk_addr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int c0, ic, dc;
    vecs[0] = '{1'b1, 1'b1, 5'b00000, 1'b1, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b1, 5'b11000, 1'b1, 32'h0000_1230};
    vecs[2] = '{1'b1, 1'b1, 5'b11000, 1'b1, 32'h0000_1234};
    vecs[3] = '{1'b1, 1'b1, 5'b11000, 1'b1, 32'h0000_1238};
    vecs[4] = '{1'b1, 1'b1, 5'b11000, 1'b1, 32'h0000_123C};
    vecs[5] = '{1'b1, 1'b1, 5'b00010, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 5'b00000, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 5'b00000, 1'b0, 32'h0};

    resetn = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ack = 1'b0;
    ack_mode = 2;
    tick();
    tick();
    chk("reset_outputs",
        {bus.m_addr, 20'd0, bus.m_req, bus.m_we, bus.i_valid, bus.d_valid,
         bus.i_done, bus.d_done, bus.d_beat, 4'd0}, 64'd0);

    // Single I refill, cycle by cycle (also covers spurious ack in IDLE).
    resetn = 1'b1;
    bus.i_addr = 32'h0000_1234;
    push_burst(32'h0000_1234, 1'b0, 1'b0);
    for (int n = 0; n < 8; n++) begin
      bus.i_req = vecs[n].i_req;
      bus.m_ack = vecs[n].m_ack;
      #1;
      chk($sformatf("vec%0d", n),
          {bus.m_req, bus.i_valid, bus.d_valid, bus.i_done, bus.d_done, 27'd0,
           (vecs[n].chk_addr ? bus.m_addr : 32'h0)},
          {vecs[n].exp_flags, 27'd0, vecs[n].exp_addr});
      tick();
    end
    chk("refill_done_count", 64'(i_done_cnt), 64'd1);

    // Conflict right after reset: D, then I, then D again on the next conflict.
    ack_mode = 0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int r = 0; r < 2; r++) begin
      ic = i_done_cnt; dc = d_done_cnt;
      bus.d_we = 1'b0;
      bus.d_addr = 32'h0000_2000 + 32'(r) * 32'h100;
      bus.i_addr = 32'h0000_3000 + 32'(r) * 32'h100;
      push_burst(bus.d_addr, 1'b0, 1'b1);
      push_burst(bus.i_addr, 1'b0, 1'b0);
      bus.d_req = 1'b1; bus.i_req = 1'b1;
      c0 = cyc;
      run_until(ic + 1, dc + 1, 40, "conflict_complete");
      chk("conflict_d_done_cycle", 64'(d_done_cyc - c0), 64'd5);
      chk("conflict_i_done_cycle", 64'(i_done_cyc - c0), 64'd11);
    end
    tick();

    // D writeback.
    dc = d_done_cnt;
    bus.d_we = 1'b1;
    bus.d_addr = 32'h0000_8000;
    push_burst(32'h0000_8000, 1'b1, 1'b1);
    bus.d_req = 1'b1;
    run_until(i_done_cnt, dc + 1, 30, "writeback_complete");
    bus.d_we = 1'b0;
    tick();

    // Stalled memory: ack every third cycle.
    ic = i_done_cnt;
    ack_mode = 1;
    bus.i_addr = 32'h0000_4008;
    push_burst(32'h0000_4000, 1'b0, 1'b0);
    bus.i_req = 1'b1;
    run_until(ic + 1, d_done_cnt, 60, "stall_complete");
    chk("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset after two beats: burst abandoned, no done, fresh request restarts.
    ack_mode = 0;
    tick();
    ic = i_done_cnt; dc = d_done_cnt;
    bus.i_addr = 32'h0000_5000;
    push_burst(32'h0000_5000, 1'b0, 1'b0);
    bus.i_req = 1'b1;
    tick();
    tick();
    tick();
    ack_mode = 2;
    bus.m_ack = 1'b0;
    resetn = 1'b0;
    tick();
    chk("midburst_reset_outputs",
        {bus.m_addr, 22'd0, bus.m_req, bus.m_we, bus.i_valid, bus.d_valid,
         bus.i_done, bus.d_done, bus.d_beat},
        64'd0);
    chk("midburst_leftover_beats", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    bus.i_req = 1'b0;
    resetn = 1'b1;
    for (int n = 0; n < 3; n++) tick();
    chk("midburst_no_done", {32'(i_done_cnt), 32'(d_done_cnt)}, {32'(ic), 32'(dc)});
    ack_mode = 0;
    bus.d_addr = 32'h0000_6000;
    push_burst(32'h0000_6000, 1'b0, 1'b1);
    bus.d_req = 1'b1;
    run_until(ic, dc + 1, 30, "restart_complete");
    tick();

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
